uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 45 ++++
 rtl/uart_tx_fifo.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: register offsets, status bit
// positions and serializer states.
package uart_pkg;

   localparam logic [3:0] AddrTxData  = 4'h0;
   localparam logic [3:0] AddrStatus  = 4'h4;
   localparam logic [3:0] AddrIntClr  = 4'h8;
   localparam logic [3:0] AddrDivisor = 4'hC;

   localparam int unsigned StatFull  = 0;
   localparam int unsigned StatEmpty = 1;
   localparam int unsigned StatBusy  = 2;
   localparam int unsigned StatOvf   = 3;

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StData,
      StStop
   } tx_state_e;

   // A programmed divisor of zero is treated as one clock per bit.
   function automatic logic [15:0] eff_div(input logic [15:0] d);
      return (d == 16'd0) ? 16'd1 : d;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data. Pointers carry one
// extra bit so full and empty are distinguishable when the indices match.
module sync_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

   logic [AW:0]      wptr_q, rptr_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             push_ok, pop_ok;

   assign empty  = (wptr_q == rptr_q);
   assign full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign pop_ok = pop & ~empty;
   // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
   assign push_ok = push & (~full | pop_ok);
   assign rdata   = mem_q[rptr_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (push_ok) wptr_q <= wptr_q + PtrOne;
         if (pop_ok)  rptr_q <= rptr_q + PtrOne;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wptr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO and a TX-done interrupt.
// The baud divisor is captured at each frame start so it never changes mid-frame.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned DIV_RESET = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cs,
   input  logic [31:0] bus_addr,
   input  logic [31:0] bus_wr_val,
   input  logic [3:0]  bus_bytesel,
   output logic        bus_ack,
   output logic [31:0] bus_data,
   output logic        txd,
   output logic        inter,
   input  logic        intack
);

   localparam logic [15:0] DivInit = 16'(DIV_RESET);

   logic        cs_q, access, is_wr, is_rd;
   logic [3:0]  addr;
   logic        tx_push, int_clr_wr, div_wr, stat_rd, tx_drop;
   logic [15:0] div_q;
   logic        ovf_q, ovf_d;
   logic        bus_ack_q;
   logic [31:0] bus_data_q, rd_data;
   logic [3:0]  status;

   logic        fifo_full, fifo_empty, fifo_pop;
   logic [7:0]  fifo_rdata;

   tx_state_e   state_q, state_d;
   logic [15:0] cnt_q, div_act_q;
   logic [2:0]  bit_idx_q;
   logic [7:0]  shreg_q;
   logic        bit_end, frame_done, busy;
   logic        txd_d, txd_q;
   logic        done_q, inter_q, inter_d;
   logic        unused_bits;

   assign unused_bits = ^{bus_addr[31:4], bus_wr_val[31:16]};

   // Side effects only on the first cycle of a select.
   assign access     = cs & ~cs_q;
   assign is_wr      = access & (|bus_bytesel);
   assign is_rd      = access & ~(|bus_bytesel);
   assign addr       = bus_addr[3:0];
   assign tx_push    = is_wr && (addr == AddrTxData);
   assign int_clr_wr = is_wr && (addr == AddrIntClr);
   assign div_wr     = is_wr && (addr == AddrDivisor);
   assign stat_rd    = is_rd && (addr == AddrStatus);
   assign tx_drop    = tx_push & fifo_full & ~fifo_pop;
   assign ovf_d      = tx_drop | (ovf_q & ~stat_rd);

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_push),
      .wdata (bus_wr_val[7:0]),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      status           = '0;
      status[StatFull]  = fifo_full;
      status[StatEmpty] = fifo_empty;
      status[StatBusy]  = busy;
      status[StatOvf]   = ovf_q;
   end

   always_comb begin
      rd_data = '0;
      if (is_rd) begin
         case (addr)
            AddrStatus:  rd_data = {28'b0, status};
            AddrDivisor: rd_data = {16'b0, div_q};
            default:     rd_data = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cs_q       <= 1'b0;
         bus_ack_q  <= 1'b0;
         bus_data_q <= '0;
         div_q      <= DivInit;
         ovf_q      <= 1'b0;
      end else begin
         cs_q       <= cs;
         bus_ack_q  <= cs;
         bus_data_q <= rd_data;
         ovf_q      <= ovf_d;
         if (div_wr) div_q <= bus_wr_val[15:0];
      end
   end

   // Serializer: state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   assign bit_end = (cnt_q == div_act_q - 16'd1);

   // Serializer: next state; a pop marks every frame start.
   always_comb begin
      state_d    = state_q;
      fifo_pop   = 1'b0;
      frame_done = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               state_d  = StStart;
               fifo_pop = 1'b1;
            end
         end
         StStart: if (bit_end) state_d = StData;
         StData:  if (bit_end && (bit_idx_q == 3'd7)) state_d = StStop;
         StStop: begin
            if (bit_end) begin
               if (!fifo_empty) begin
                  state_d  = StStart;
                  fifo_pop = 1'b1;
               end else begin
                  state_d    = StIdle;
                  frame_done = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Serializer: outputs.
   always_comb begin
      txd_d = 1'b1;
      busy  = (state_q != StIdle);
      unique case (state_q)
         StIdle:  txd_d = 1'b1;
         StStart: txd_d = 1'b0;
         StData:  txd_d = shreg_q[0];
         StStop:  txd_d = 1'b1;
         default: txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shreg_q   <= '0;
         div_act_q <= eff_div(DivInit);
      end else if (fifo_pop) begin
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shreg_q   <= fifo_rdata;
         div_act_q <= eff_div(div_q);
      end else if (state_q != StIdle) begin
         if (bit_end) begin
            cnt_q <= '0;
            if (state_q == StData) begin
               bit_idx_q <= bit_idx_q + 3'd1;
               shreg_q   <= shreg_q >> 1;
            end
         end else begin
            cnt_q <= cnt_q + 16'd1;
         end
      end
   end

   // Interrupt sets one cycle after the return to idle; a set beats a clear.
   assign inter_d = done_q | (inter_q & ~(intack | int_clr_wr));

   always_ff @(posedge clk) begin
      if (rst) begin
         txd_q   <= 1'b1;
         done_q  <= 1'b0;
         inter_q <= 1'b0;
      end else begin
         txd_q   <= txd_d;
         done_q  <= frame_done;
         inter_q <= inter_d;
      end
   end

   assign bus_ack  = bus_ack_q;
   assign bus_data = bus_data_q;
   assign txd      = txd_q;
   assign inter    = inter_q;

endmodule
